// File: rtl/video_mode_tracker.sv
// Video mode tracker: measures active width and content lines of each frame from the raw core
// timing, classifies them, and commits a debounced mode for the line buffer and the scaler.
module video_mode_tracker #(
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned TIMEOUT_LINES = 1000,
  parameter int unsigned SLOT0_MAX     = 280,
  parameter int unsigned SLOT1_MAX     = 380,
  parameter int unsigned LINE224_MAX   = 231
) (
  input  logic       clk_vid,
  input  logic       reset,
  input  logic       vsync_in,
  input  logic       hsync_in,
  input  logic       ce_pix,
  input  logic       disable_pix,
  output logic [2:0] slot,
  output logic       line_224,
  output logic [9:0] expected_width,
  output logic [9:0] expected_lines,
  output logic       mode_valid,
  output logic       mode_changed,
  output logic [9:0] meas_width,
  output logic [9:0] meas_lines
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_LINES + 1);

  localparam logic [9:0]       Slot0Max   = 10'(SLOT0_MAX);
  localparam logic [9:0]       Slot1Max   = 10'(SLOT1_MAX);
  localparam logic [9:0]       Line224Max = 10'(LINE224_MAX);
  localparam logic [9:0]       CntMax     = 10'd1023;
  localparam logic [3:0]       StableN    = 4'(STABLE_FRAMES);
  localparam logic [IdleW-1:0] IdleMax    = IdleW'(TIMEOUT_LINES);
  localparam logic [IdleW-1:0] IdleLast   = IdleW'(TIMEOUT_LINES - 1);

  typedef enum logic [1:0] {StWaitVsync, StAcquire, StLocked} state_e;

  state_e           state_q;
  logic             prev_vs_q, prev_hs_q;
  logic [9:0]       pix_cnt_q, line_cnt_q, max_w_q;
  logic [IdleW-1:0] idle_q;
  logic [1:0]       pend_slot_q;
  logic             pend_224_q;
  logic [3:0]       stab_q;

  logic       vs_rise, hs_rise, line_has_pix, timeout, classify, commit;
  logic [9:0] fold_lines, fold_max;
  logic [1:0] cand_slot, pend_slot_d;
  logic       cand_224, pend_224_d;
  logic [3:0] stab_d;

  assign vs_rise      = vsync_in & ~prev_vs_q;
  assign hs_rise      = hsync_in & ~prev_hs_q;
  assign line_has_pix = hs_rise && (pix_cnt_q != 10'd0);
  // The vsync edge wins over a coincident timeout: the frame is closing anyway.
  assign timeout      = hs_rise && !vs_rise && (idle_q == IdleLast);
  // The first vsync after reset or timeout closes a partial frame and is not classified.
  assign classify     = vs_rise && (state_q != StWaitVsync);

  // Fold a line ending on this cycle into the frame totals, then classify the result.
  always_comb begin
    fold_lines = line_cnt_q;
    fold_max   = max_w_q;
    if (line_has_pix) begin
      if (line_cnt_q != CntMax) fold_lines = line_cnt_q + 10'd1;
      if (pix_cnt_q > max_w_q)  fold_max   = pix_cnt_q;
    end
    if (fold_max < Slot0Max)      cand_slot = 2'd0;
    else if (fold_max < Slot1Max) cand_slot = 2'd1;
    else                          cand_slot = 2'd2;
    cand_224 = fold_lines < Line224Max;
  end

  // Pending-mode debounce; blank frames restart the stability count.
  always_comb begin
    pend_slot_d = pend_slot_q;
    pend_224_d  = pend_224_q;
    stab_d      = stab_q;
    commit      = 1'b0;
    if (classify) begin
      if (fold_lines == 10'd0) begin
        stab_d = 4'd0;
      end else if (cand_slot == pend_slot_q && cand_224 == pend_224_q) begin
        if (stab_q < StableN) stab_d = stab_q + 4'd1;
      end else begin
        pend_slot_d = cand_slot;
        pend_224_d  = cand_224;
        stab_d      = 4'd1;
      end
      commit = (fold_lines != 10'd0) && (stab_d == StableN) &&
               ((state_q == StAcquire) ||
                (pend_slot_d != slot[1:0]) || (pend_224_d != line_224));
    end
  end

  // Per-line and per-frame measurement counters.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      prev_vs_q  <= 1'b0;
      prev_hs_q  <= 1'b0;
      pix_cnt_q  <= 10'd0;
      line_cnt_q <= 10'd0;
      max_w_q    <= 10'd0;
      idle_q     <= '0;
    end else begin
      prev_vs_q <= vsync_in;
      prev_hs_q <= hsync_in;
      if (vs_rise) begin
        pix_cnt_q  <= 10'd0;
        line_cnt_q <= 10'd0;
        max_w_q    <= 10'd0;
      end else if (hs_rise) begin
        pix_cnt_q  <= 10'd0;
        line_cnt_q <= fold_lines;
        max_w_q    <= fold_max;
      end else if (ce_pix && !disable_pix && pix_cnt_q != CntMax) begin
        pix_cnt_q <= pix_cnt_q + 10'd1;
      end
      if (vs_rise)                              idle_q <= '0;
      else if (hs_rise && idle_q != IdleMax)    idle_q <= idle_q + IdleW'(1);
    end
  end

  // Lock FSM with registered mode outputs; committed mode survives a timeout.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      state_q        <= StWaitVsync;
      pend_slot_q    <= 2'd0;
      pend_224_q     <= 1'b0;
      stab_q         <= 4'd0;
      slot           <= 3'd0;
      line_224       <= 1'b0;
      expected_width <= 10'd256;
      expected_lines <= 10'd240;
      mode_valid     <= 1'b0;
      mode_changed   <= 1'b0;
      meas_width     <= 10'd0;
      meas_lines     <= 10'd0;
    end else begin
      mode_changed <= 1'b0;
      if (timeout) begin
        state_q    <= StWaitVsync;
        mode_valid <= 1'b0;
        stab_q     <= 4'd0;
      end else begin
        pend_slot_q <= pend_slot_d;
        pend_224_q  <= pend_224_d;
        stab_q      <= stab_d;
        if (classify) begin
          meas_width <= fold_max;
          meas_lines <= fold_lines;
        end
        unique case (state_q)
          StWaitVsync: if (vs_rise) state_q <= StAcquire;
          StAcquire, StLocked: begin
            if (commit) begin
              slot           <= {1'b0, pend_slot_d};
              line_224       <= pend_224_d;
              expected_lines <= pend_224_d ? 10'd224 : 10'd240;
              unique case (pend_slot_d)
                2'd0:    expected_width <= 10'd256;
                2'd1:    expected_width <= 10'd360;
                default: expected_width <= 10'd512;
              endcase
              mode_changed <= 1'b1;
              mode_valid   <= 1'b1;
              state_q      <= StLocked;
            end
          end
          default: state_q <= StWaitVsync;
        endcase
      end
    end
  end

endmodule
